// File: rtl/debounce_pulse_pkg.sv
// rtl/debounce_pulse_pkg.sv - FSM encodings and elaboration helpers shared by the push-button conditioner.
package debounce_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    // Counter width that never collapses to zero bits for tiny parameter values.
    function automatic int clog2_min1(input int unsigned value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - Push-button synchroniser, debouncer and press/release strobe generator.
// Auto-repeat of o_press while held is built only when DEBOUNCE_PULSE_REPEAT_EN is defined.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 250000,
    parameter int ACTIVE_LOW          = 0,
    parameter int REPEAT_DELAY_CYCLES = 12500000,
    parameter int REPEAT_RATE_CYCLES  = 2500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int            CNT_W        = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic          RELEASED_RAW = (ACTIVE_LOW != 0);

    logic             btn_sync;
    logic             btn_s;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             accept_press;
    logic             accept_release;
    logic             rpt_fire;

    // Synchroniser resets to the raw "released" value so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (RELEASED_RAW)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_btn),
        .o_q     (btn_sync)
    );

    assign btn_s = btn_sync ^ RELEASED_RAW;

    assign accept_press   = (state_q == ST_PRESS_WAIT)   &&  btn_s && (cnt_q == CNT_LAST);
    assign accept_release = (state_q == ST_RELEASE_WAIT) && !btn_s && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The stability counter restarts on every state entry, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = level_q;
        press_d   = accept_press | rpt_fire;
        release_d = accept_release;
        if (accept_press) begin
            level_d = 1'b1;
        end else if (accept_release) begin
            level_d = 1'b0;
        end
    end

`ifdef DEBOUNCE_PULSE_REPEAT_EN
    localparam int               RPT_W          = clog2_min1(max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             rpt_armed_q;
    logic             rpt_armed_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    // rpt_armed_q selects the initial delay versus the steady repeat interval.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        if (accept_press) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (state_q == ST_HELD) begin
            if (rpt_cnt_q == (rpt_armed_q ? RPT_RATE_LAST : RPT_DELAY_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule
